// File: rtl/test_monitor.sv
// End-of-test monitor for the riscv-tests harness: watches retires, gp and stores,
// and latches a sticky pass/fail/timeout verdict that also halts the core.
module test_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter bit          ECALL_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire_valid,
    input  logic [31:0] retire_inst,
    input  logic [31:0] gp_value,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [1:0]  status,
    output logic        done,
    output logic        halt,
    output logic [30:0] fail_testnum,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        PASS    = 2'b01,
        FAIL    = 2'b10,
        TIMEOUT = 2'b11
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [31:0] ECALL_INST   = 32'h0000_0073;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [30:0] fail_testnum_r;
    logic [30:0] fail_nxt_s;
    logic [31:0] cycle_count_r;
    logic [31:0] cycle_nxt_s;
    logic [31:0] instret_count_r;
    logic [31:0] instret_nxt_s;
    logic        done_r;
    logic        done_nxt_s;
    logic        tohost_hit_s;
    logic        ecall_hit_s;
    logic        timeout_hit_s;
    logic        in_run_s;

    // Only odd tohost writes terminate; even values are syscall proxy traffic.
    assign tohost_hit_s  = mem_we && (mem_addr[31:2] == TOHOST_ADDR[31:2]) && mem_wdata[0];
    assign ecall_hit_s   = ECALL_EN && retire_valid && (retire_inst == ECALL_INST);
    assign timeout_hit_s = (cycle_count_r == TIMEOUT_LAST);
    assign in_run_s      = (state_r == RUN);

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= RUN;
            fail_testnum_r  <= 31'd0;
            cycle_count_r   <= 32'd0;
            instret_count_r <= 32'd0;
            done_r          <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            fail_testnum_r  <= fail_nxt_s;
            cycle_count_r   <= cycle_nxt_s;
            instret_count_r <= instret_nxt_s;
            done_r          <= done_nxt_s;
        end
    end

    // Next-state: tohost outranks ecall, which outranks timeout; verdicts are terminal.
    always_comb begin
        state_nxt_s = state_r;
        fail_nxt_s  = fail_testnum_r;
        case (state_r)
            RUN: begin
                if (tohost_hit_s) begin
                    if (mem_wdata == 32'd1) begin
                        state_nxt_s = PASS;
                    end else begin
                        state_nxt_s = FAIL;
                        fail_nxt_s  = mem_wdata[31:1];
                    end
                end else if (ecall_hit_s) begin
                    if (gp_value == 32'd1) begin
                        state_nxt_s = PASS;
                    end else if (gp_value[0]) begin
                        state_nxt_s = FAIL;
                        fail_nxt_s  = gp_value[31:1];
                    end else begin
                        state_nxt_s = FAIL;
                        fail_nxt_s  = 31'd0;
                    end
                end else if (timeout_hit_s) begin
                    state_nxt_s = TIMEOUT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            PASS, FAIL, TIMEOUT: begin
                state_nxt_s = state_r;
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // Output next values: saturating counters that run only in RUN.
    always_comb begin
        cycle_nxt_s   = cycle_count_r;
        instret_nxt_s = instret_count_r;
        if (in_run_s && (cycle_count_r != 32'hFFFF_FFFF)) begin
            cycle_nxt_s = cycle_count_r + 32'd1;
        end else begin
            cycle_nxt_s = cycle_count_r;
        end
        if (in_run_s && retire_valid && (instret_count_r != 32'hFFFF_FFFF)) begin
            instret_nxt_s = instret_count_r + 32'd1;
        end else begin
            instret_nxt_s = instret_count_r;
        end
        done_nxt_s = (state_nxt_s != RUN);
    end

    assign status        = state_r;
    assign done          = done_r;
    assign halt          = done_r;
    assign fail_testnum  = fail_testnum_r;
    assign cycle_count   = cycle_count_r;
    assign instret_count = instret_count_r;

endmodule

// File: tb/tb_test_monitor.sv
// Scoreboard bench for test_monitor: directed vectors push expected verdicts,
// a negedge monitor pops and compares them when done rises.
module tb_test_monitor;

    localparam logic [31:0] TOHOST = 32'h0000_1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        retire_valid;
    logic [31:0] retire_inst, gp_value, mem_addr, mem_wdata;
    logic        mem_we;

    logic [1:0]  status_a, status_b;
    logic        done_a, done_b, halt_a, halt_b;
    logic [30:0] tn_a, tn_b;
    logic [31:0] cc_a, cc_b, ic_a, ic_b;

    always #5 clk = ~clk;

    test_monitor dut_a (
        .clk(clk), .rst(rst_a), .retire_valid(retire_valid), .retire_inst(retire_inst),
        .gp_value(gp_value), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .status(status_a), .done(done_a), .halt(halt_a), .fail_testnum(tn_a),
        .cycle_count(cc_a), .instret_count(ic_a)
    );

    test_monitor #(.TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .rst(rst_b), .retire_valid(retire_valid), .retire_inst(retire_inst),
        .gp_value(gp_value), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .status(status_b), .done(done_b), .halt(halt_b), .fail_testnum(tn_b),
        .cycle_count(cc_b), .instret_count(ic_b)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic [30:0] tn;
        logic [31:0] cc;
        logic [31:0] ic;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks   = 0;
    int   failures = 0;
    logic done_a_q = 1'b0;
    logic done_b_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cmp_verdict(input string who, input exp_t e, input logic [1:0] st,
                               input logic [30:0] tn, input logic [31:0] cc,
                               input logic [31:0] ic, input logic hl);
        chk({who, "_status"},  {30'd0, st}, {30'd0, e.st});
        chk({who, "_testnum"}, {1'b0, tn},  {1'b0, e.tn});
        chk({who, "_cycles"},  cc, e.cc);
        chk({who, "_instret"}, ic, e.ic);
        chk({who, "_halt"},    {31'd0, hl}, 32'd1);
    endtask

    // Monitor: each rising done consumes one expected verdict.
    always @(negedge clk) begin
        if (done_a && !done_a_q) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_verdict: got status %0d want none", status_a);
            end else begin
                cmp_verdict("a", q_a.pop_front(), status_a, tn_a, cc_a, ic_a, halt_a);
            end
        end
        if (done_b && !done_b_q) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_verdict: got status %0d want none", status_b);
            end else begin
                cmp_verdict("b", q_b.pop_front(), status_b, tn_b, cc_b, ic_b, halt_b);
            end
        end
        done_a_q <= done_a;
        done_b_q <= done_b;
    end

    task automatic idle();
        retire_valid = 1'b0;
        retire_inst  = NOP;
        gp_value     = 32'd0;
        mem_we       = 1'b0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ecall(input logic [31:0] gp);
        retire_valid = 1'b1;
        retire_inst  = ECALL;
        gp_value     = gp;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        mem_we    = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
    endtask

    task automatic chk_zero_a(input string name);
        chk({name, "_status"},  {30'd0, status_a}, 32'd0);
        chk({name, "_done"},    {31'd0, done_a},   32'd0);
        chk({name, "_halt"},    {31'd0, halt_a},   32'd0);
        chk({name, "_testnum"}, {1'b0, tn_a},      32'd0);
        chk({name, "_cycles"},  cc_a,              32'd0);
        chk({name, "_instret"}, ic_a,              32'd0);
    endtask

    // Off-edge reset pulse on dut_a; released 1 time unit after the next rising edge.
    task automatic reset_a(input string name);
        idle();
        #2;
        rst_a = 1'b1;
        #1;
        chk_zero_a(name);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst_a = 1'b1;
        rst_b = 1'b1;
        #2;
        chk_zero_a("reset_state");
        @(posedge clk);
        #1;
        rst_a = 1'b0;

        // Ecall pass: 20 retires, ecall with gp=1 while cycle_count=30.
        for (int c = 0; c < 30; c++) begin
            retire_valid = (c < 20);
            tick();
        end
        ecall(32'd1);
        q_a.push_back('{2'b01, 31'd0, 32'd31, 32'd21});
        #1;
        chk("ecall_pass_no_comb_path", {30'd0, status_a}, 32'd0);
        tick();
        idle();
        retire_valid = 1'b1;
        repeat (3) tick();
        chk("pass_frozen_cycles", cc_a, 32'd31);
        chk("pass_frozen_instret", ic_a, 32'd21);
        chk("pass_sticky", {30'd0, status_a}, 32'd1);
        reset_a("rst_in_pass");

        // Ecall fail with gp=7, then a tohost pass write must not change anything.
        repeat (5) tick();
        ecall(32'd7);
        q_a.push_back('{2'b10, 31'd3, 32'd6, 32'd1});
        tick();
        idle();
        store(TOHOST, 32'd1);
        tick();
        idle();
        chk("fail_ignores_tohost_status", {30'd0, status_a}, 32'd2);
        chk("fail_ignores_tohost_testnum", {1'b0, tn_a}, 32'd3);
        chk("fail_frozen_cycles", cc_a, 32'd6);
        reset_a("rst_in_fail");

        // Even tohost value ignored; then tohost 0xB at TOHOST+2 beats ecall gp=1.
        store(TOHOST, 32'd2);
        tick();
        chk("tohost_even_ignored", {30'd0, status_a}, 32'd0);
        store(TOHOST + 32'd2, 32'h0000_000B);
        ecall(32'd1);
        q_a.push_back('{2'b10, 31'd5, 32'd2, 32'd1});
        tick();
        idle();
        tick();
        reset_a("rst_after_tohost_fail");

        // Malformed exit: even gp.
        ecall(32'd4);
        q_a.push_back('{2'b10, 31'd0, 32'd1, 32'd1});
        tick();
        idle();
        tick();
        reset_a("rst_after_malformed");

        // Odd store to the neighbouring word is ignored; tohost=1 passes.
        store(TOHOST + 32'd4, 32'd1);
        tick();
        chk("tohost_other_word_ignored", {30'd0, status_a}, 32'd0);
        store(TOHOST, 32'd1);
        q_a.push_back('{2'b01, 31'd0, 32'd2, 32'd0});
        tick();
        idle();
        tick();
        reset_a("rst_after_tohost_pass");

        // Reset mid-run at cycle 15, then restart and pass.
        repeat (15) tick();
        chk("midrun_cycles_before_rst", cc_a, 32'd15);
        reset_a("rst_mid_run");
        chk("restart_cycles_zero", cc_a, 32'd0);
        repeat (3) tick();
        chk("restart_cycles_three", cc_a, 32'd3);
        ecall(32'd1);
        q_a.push_back('{2'b01, 31'd0, 32'd4, 32'd1});
        tick();
        idle();
        tick();
        rst_a = 1'b1;

        // Timeout with TIMEOUT_CYCLES=8.
        rst_b = 1'b0;
        q_b.push_back('{2'b11, 31'd0, 32'd8, 32'd0});
        repeat (7) tick();
        chk("timeout_not_yet_status", {30'd0, status_b}, 32'd0);
        chk("timeout_not_yet_cycles", cc_b, 32'd7);
        tick();
        chk("timeout_at_8th_edge", {30'd0, status_b}, 32'd3);
        repeat (10) tick();
        chk("timeout_hold_cycles", cc_b, 32'd8);
        chk("timeout_hold_status", {30'd0, status_b}, 32'd3);

        // Ecall pass in the cycle cycle_count=7 beats timeout.
        #2;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        repeat (7) tick();
        ecall(32'd1);
        q_b.push_back('{2'b01, 31'd0, 32'd8, 32'd1});
        tick();
        idle();
        tick();
        chk("ecall_beats_timeout", {30'd0, status_b}, 32'd1);

        tick();
        chk("queue_a_drained", q_a.size(), 32'd0);
        chk("queue_b_drained", q_b.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/test_monitor.md
# test_monitor

Synthesizable end-of-test monitor that sits directly downstream of the RISC-V core inside the riscv-tests simulation harness. It observes the core's instruction-retire stream, the `gp` (x3) register and data-memory stores. It decides pass, fail or timeout by the riscv-tests conventions (`ecall` with `gp`, or a store to `tohost`). The bench checks one sticky status word instead of sampling `core.rs[3]` after a fixed tick count. Its `halt` output freezes the core once a verdict exists.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 5000, cycles after reset release before declaring timeout; must be ≥ 2.
- `TOHOST_ADDR`, 32'h0000_1000, word address of the `tohost` symbol.
- `ECALL_EN`, 1, when 1, a retired `ecall` terminates the test using `gp`; when 0, `ecall` is ignored.

Ports:
- `clk`  input  1  single clock; all logic on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `retire_valid`  input  1  one instruction retires this cycle.
- `retire_inst`  input  32  encoding of the retiring instruction.
- `gp_value`  input  32  current x3 value, already including any same-cycle writeback.
- `mem_we`  input  1  data-memory store this cycle.
- `mem_addr`  input  32  store byte address.
- `mem_wdata`  input  32  store data.
- `status`  output  2  verdict: 00 running, 01 pass, 10 fail, 11 timeout.
- `done`  output  1  high when `status` != 00.
- `halt`  output  1  equal to `done`; the core stalls fetch and retire while high.
- `fail_testnum`  output  31  failing test number; 0 unless `status` = 10.
- `cycle_count`  output  32  cycles counted in RUN.
- `instret_count`  output  32  instructions retired in RUN.

## Operation
- FSM states: RUN, PASS, FAIL, TIMEOUT. Reset enters RUN. PASS, FAIL and TIMEOUT are terminal until `rst`.
- Termination events are evaluated in RUN only.
  - **Tohost event:** `mem_we` && `mem_addr[31:2]` == `TOHOST_ADDR[31:2]` && `mem_wdata[0]` == 1.
    - `mem_wdata` == 1 → PASS.
    - Any other odd value → FAIL, with `fail_testnum` = `mem_wdata[31:1]`.
    - Even values, including 0, are ignored (syscall proxy traffic).
  - **Ecall event:** `ECALL_EN` && `retire_valid` && `retire_inst` == 32'h0000_0073.
    - `gp_value` == 1 → PASS.
    - `gp_value[0]` == 1 and `gp_value` != 1 → FAIL, with `fail_testnum` = `gp_value[31:1]`.
    - `gp_value` even → FAIL, with `fail_testnum` = 0 (malformed exit).
  - **Timeout event:** `cycle_count` == `TIMEOUT_CYCLES`-1 in a cycle with no other event → TIMEOUT.
- Priority when events coincide: tohost > ecall > timeout.
- `cycle_count`:
  - Increments every cycle in RUN, including the terminating cycle.
  - Frozen in terminal states.
  - Saturates at 32'hFFFF_FFFF.
- `instret_count`:
  - Increments on `retire_valid` in RUN; a terminating `ecall` is counted.
  - Frozen in terminal states.
  - Saturates at 32'hFFFF_FFFF.
- `fail_testnum` is captured in the same edge as the FAIL transition and held.
- Inputs are ignored in terminal states, including further stores to `tohost`.

## Timing
- Reset values:
  - `status` = 00, `done` = 0, `halt` = 0.
  - `fail_testnum` = 0, `cycle_count` = 0, `instret_count` = 0.
- Asserting `rst` at any time, including mid-test or in a terminal state, clears all outputs asynchronously. Counting resumes on the first rising edge with `rst` low.
- Latency: an event sampled at edge N appears on `status`, `done` and `halt` after edge N (registered, 1 cycle). There is no combinational path from inputs to outputs.
- The first RUN cycle after reset release has `cycle_count` = 0.
- With no events, the TIMEOUT transition happens at the edge where `cycle_count` reads `TIMEOUT_CYCLES`-1. `cycle_count` then holds `TIMEOUT_CYCLES`.
- `halt` rises 1 cycle after the terminating event, so the core may retire at most one further instruction; the monitor does not count it.
- Terminal states never time out and never revert.

## Test plan
- **Ecall pass:** 20 retires, then `ecall` with `gp` = 1 at cycle 30 → `status` = 01 and `done` = 1 from cycle 31; `instret_count` = 21; `cycle_count` = 31.
- **Ecall fail:** `ecall` with `gp` = 32'h0000_0007 → `status` = 10, `fail_testnum` = 3. A later `tohost` write of 1 leaves the state unchanged.
- **Tohost vs ecall same cycle:** store of 32'h0000_000B to `TOHOST_ADDR`+2 coincident with `ecall`, `gp` = 1 → `status` = 10, `fail_testnum` = 5. Also, a store of 32'h2 to `TOHOST_ADDR` → ignored, `status` stays 00.
- **Timeout:** `TIMEOUT_CYCLES` = 8, no events → `status` = 11 after the 8th edge; `cycle_count` = 8 and stays 8 for 10 more cycles.
- **Timeout vs event:** `ecall` with `gp` = 1 in the cycle `cycle_count` = 7 (`TIMEOUT_CYCLES` = 8) → `status` = 01.
- **Reset mid-run and in a terminal state:** `rst` pulsed off-edge at cycle 15 during RUN, and again while in PASS → all outputs 0 immediately; after release, `cycle_count` restarts at 0 and a later `ecall` with `gp` = 1 yields PASS.
